ooo_reorder_buffer: RTL

//  Parametrised reorder buffer and register alias table for the out-of-order core. Sits between decode/dispatch and the register file.
//  - Allocates one tagged entry per dispatched instruction.
//  - Resolves source operands through the alias table, with same-cycle writeback bypass.
//  - Accepts out-of-order writebacks by tag and retires in program order (max 1/cycle).
//  - Supports a full pipeline flush.

---
 rtl/ooo_reorder_buffer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ooo_reorder_buffer.sv
// Reorder buffer with register alias table: in-order allocate, out-of-order
// writeback by tag, in-order retire (one per cycle), full flush.
module ooo_reorder_buffer #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int PC_W   = 8,
    parameter int DEPTH  = 8,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [REG_AW-1:0] alloc_dest,
    input  logic [PC_W-1:0]   alloc_pc,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic [REG_AW-1:0] src_a_addr,
    input  logic [DATA_W-1:0] reg_a_data,
    output logic              src_a_ready,
    output logic [TAG_W-1:0]  src_a_tag,
    output logic [DATA_W-1:0] src_a_value,
    input  logic [REG_AW-1:0] src_b_addr,
    input  logic [DATA_W-1:0] reg_b_data,
    output logic              src_b_ready,
    output logic [TAG_W-1:0]  src_b_tag,
    output logic [DATA_W-1:0] src_b_value,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_error,
    output logic              commit_valid,
    output logic [REG_AW-1:0] commit_reg,
    output logic [DATA_W-1:0] commit_data,
    output logic [PC_W-1:0]   commit_pc,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [TAG_W:0]    count,
    output logic              full,
    output logic              empty
);
    localparam int NREG = 1 << REG_AW;

    logic [DEPTH-1:0]  ent_valid, ent_ready;
    logic [REG_AW-1:0] ent_dest [DEPTH];
    logic [PC_W-1:0]   ent_pc   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic [NREG-1:0]   rat_pend;
    logic [TAG_W-1:0]  rat_tag [NREG];

    logic [TAG_W-1:0]  head, tail;
    logic              alloc_fire, commit_fire, wb_ok;

    assign full        = (count == (TAG_W+1)'(DEPTH));
    assign empty       = (count == '0);
    assign alloc_ready = !full && !flush;
    assign alloc_tag   = tail;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = ent_valid[head] && ent_ready[head];
    assign wb_ok       = wb_valid && ent_valid[wb_tag] && !ent_ready[wb_tag];

    // Operand lookup sees pre-alloc state, so src==dest resolves to the older producer.
    logic [REG_AW-1:0] src_addr [2];
    logic [DATA_W-1:0] reg_data [2];
    logic              src_rdy  [2];
    logic [TAG_W-1:0]  src_tg   [2];
    logic [DATA_W-1:0] src_val  [2];

    assign src_addr[0] = src_a_addr;
    assign src_addr[1] = src_b_addr;
    assign reg_data[0] = reg_a_data;
    assign reg_data[1] = reg_b_data;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            src_rdy[i] = 1'b0;
            src_tg[i]  = '0;
            src_val[i] = '0;
            if (src_addr[i] == '0 || !rat_pend[src_addr[i]]) begin
                src_rdy[i] = 1'b1;
                src_val[i] = reg_data[i];
            end else begin
                src_tg[i] = rat_tag[src_addr[i]];
                if (ent_ready[src_tg[i]]) begin
                    src_rdy[i] = 1'b1;
                    src_val[i] = ent_data[src_tg[i]];
                end else if (wb_valid && wb_tag == src_tg[i]) begin
                    src_rdy[i] = 1'b1;
                    src_val[i] = wb_data;
                end
            end
        end
    end

    assign src_a_ready = src_rdy[0];
    assign src_a_tag   = src_tg[0];
    assign src_a_value = src_val[0];
    assign src_b_ready = src_rdy[1];
    assign src_b_tag   = src_tg[1];
    assign src_b_value = src_val[1];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ent_valid    <= '0;
            ent_ready    <= '0;
            rat_pend     <= '0;
            commit_valid <= 1'b0;
            commit_reg   <= '0;
            commit_data  <= '0;
            commit_pc    <= '0;
            commit_tag   <= '0;
            wb_error     <= 1'b0;
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) ent_data[i] <= '0;
            end
        end else begin
            wb_error <= wb_valid && !wb_ok;
            if (wb_ok) begin
                ent_data[wb_tag]  <= wb_data;
                ent_ready[wb_tag] <= 1'b1;
            end

            commit_valid <= commit_fire;
            if (commit_fire) begin
                commit_reg      <= ent_dest[head];
                commit_data     <= ent_data[head];
                commit_pc       <= ent_pc[head];
                commit_tag      <= head;
                ent_valid[head] <= 1'b0;
                ent_ready[head] <= 1'b0;
                head            <= head + TAG_W'(1);
                // Only the newest producer owns the mapping; older retirements leave it alone.
                if (rat_tag[ent_dest[head]] == head) rat_pend[ent_dest[head]] <= 1'b0;
            end

            // Placed after the commit clear so a same-cycle rename of the same dest wins.
            if (alloc_fire) begin
                ent_valid[tail] <= 1'b1;
                ent_ready[tail] <= 1'b0;
                ent_dest[tail]  <= alloc_dest;
                ent_pc[tail]    <= alloc_pc;
                tail            <= tail + TAG_W'(1);
                if (alloc_dest != '0) begin
                    rat_pend[alloc_dest] <= 1'b1;
                    rat_tag[alloc_dest]  <= tail;
                end
            end

            count <= count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);
        end
    end
endmodule
